dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 is the MA stage, port 1 the debug/loader port.
//  Per access: round-robin grant, a request/grant handshake, alignment checking, and command hold until the memory

---
 rtl/dmem_arbiter_pkg.sv | 31 +++
 rtl/dmem_arbiter_rr_arb2.sv | 35 +++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - access size codes driven on *_size / mem_size
//   - FSM state encoding used by the top
//   - misalign(): decides whether a request is rejected without touching memory
package dmem_arbiter_pkg;

  localparam int unsigned DefaultAddrW = 10;

  localparam logic [1:0] SzB = 2'd0;
  localparam logic [1:0] SzH = 2'd1;
  localparam logic [1:0] SzW = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  // Size code 3 is undefined and is rejected like any misaligned access.
  function automatic logic misalign(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SzB:     bad = 1'b0;
      SzH:     bad = addr_lo[0];
      SzW:     bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker.
//   clk2, rst : clock and asynchronous active-high reset
//   req[1:0]  : request vector (bit 0 = MA port, bit 1 = debug/loader port)
//   advance   : a grant is being issued this cycle; remember its owner
//   grant[1:0]: one-hot pick (combinational), all-zero when nobody requests
module dmem_arbiter_rr_arb2 (
  input  logic       clk2,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Resets to 1 so that port 0 wins the first tie.
  logic last_owner_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_owner_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      last_owner_q <= 1'b1;
    end else if (advance) begin
      last_owner_q <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MA stage (port 0) and the debug/loader
// port (port 1). One access at a time: IDLE (grant) -> BUSY (command held until mem_ready)
// -> RESP (one-cycle rvalid). Misaligned requests skip BUSY and complete with err=1.
//   clk2, rst            : clock, asynchronous active-high reset
//   mN_req/we/size/addr/wdata : request payload, held until mN_gnt
//   mN_gnt               : one-cycle accept pulse
//   mN_rvalid/rdata/err  : one-cycle completion, data/err zero outside rvalid
//   mem_*                : command to the memory, mem_ready completes it
//   ma_stall             : freezes the pipeline while the MA access is outstanding
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AddrW = DefaultAddrW
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [1:0]       m0_size,
  input  logic [AddrW-1:0] m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [1:0]       m1_size,
  input  logic [AddrW-1:0] m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic [AddrW-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             ma_stall
);

  state_e           state_q;
  logic             owner_q;
  logic             cmd_we_q;
  logic [1:0]       cmd_size_q;
  logic [AddrW-1:0] cmd_addr_q;
  logic [31:0]      cmd_wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [1:0]       grant;
  logic             advance;
  logic             sel_we;
  logic [1:0]       sel_size;
  logic [AddrW-1:0] sel_addr;
  logic [31:0]      sel_wdata;
  logic             resp;

  // Grants are decoded combinationally so gnt lands in the request cycle; gating with rst
  // keeps them low while reset is held even if a requester is still asserting req.
  assign advance = (state_q == StIdle) && !rst && (m0_req || m1_req);

  dmem_arbiter_rr_arb2 u_rr_arb2 (
    .clk2    (clk2),
    .rst     (rst),
    .req     ({m1_req, m0_req}),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    sel_we    = m0_we;
    sel_size  = m0_size;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant[1]) begin
      sel_we    = m1_we;
      sel_size  = m1_size;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_size_q  <= 2'b00;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (advance) begin
            owner_q     <= grant[1];
            cmd_we_q    <= sel_we;
            cmd_size_q  <= sel_size;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            if (misalign(sel_size, sel_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (mem_ready) begin
            rdata_q <= cmd_we_q ? 32'd0 : mem_rdata;
            state_q <= StResp;
          end
        end
        StResp: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_gnt    = advance && grant[0];
  assign m1_gnt    = advance && grant[1];

  assign resp      = (state_q == StResp);
  assign m0_rvalid = resp && !owner_q;
  assign m1_rvalid = resp && owner_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : 32'd0;
  assign m1_rdata  = m1_rvalid ? rdata_q : 32'd0;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

  assign mem_en    = (state_q == StBusy);
  assign mem_we    = mem_en && cmd_we_q;
  assign mem_size  = mem_en ? cmd_size_q : 2'b00;
  assign mem_addr  = mem_en ? cmd_addr_q : '0;
  assign mem_wdata = mem_en ? cmd_wdata_q : 32'd0;

  assign ma_stall  = m0_req && !m0_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Stimulus pushes the expected memory command and the
// expected response into queues; a memory responder and a response monitor pop and compare.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk2 = 1'b0;
  logic        rst  = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, mem_ready, ma_stall;
  logic [1:0]  mem_size;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AddrW(10)) dut (
    .clk2      (clk2),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_size   (m0_size),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_size   (m1_size),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ma_stall  (ma_stall)
  );

  always #5 clk2 = ~clk2;

  int cyc = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [15:0] delay;  // mem_en cycles before mem_ready
  } cmd_t;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem_model [0:1023];

  // Memory responder: checks each new command against the scoreboard, checks it is held
  // stable, and raises mem_ready after the requested number of wait cycles.
  initial begin : mem_resp
    cmd_t cur;
    logic active;
    int   waited;
    active    = 1'b0;
    waited    = 0;
    cur       = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk2);
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      if (rst || !mem_en) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          waited = 0;
          chk("mem_cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
          if (cmd_q.size() != 0) begin
            cur = cmd_q.pop_front();
            chk("mem_cmd", 32'({mem_we, mem_size, mem_addr}), 32'({cur.we, cur.size, cur.addr}));
            chk("mem_wdata", mem_wdata, cur.wdata);
          end else begin
            cur = '{we: mem_we, size: mem_size, addr: mem_addr, wdata: mem_wdata, delay: 16'd0};
          end
        end else begin
          chk("mem_cmd_stable", 32'({mem_we, mem_size, mem_addr}), 32'({cur.we, cur.size, cur.addr}));
          chk("mem_wdata_stable", mem_wdata, cur.wdata);
        end
        if (waited == int'(cur.delay)) begin
          mem_ready = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
          active = 1'b0;
        end else begin
          waited++;
        end
      end
    end
  end

  // Response monitor plus request-protocol tracker.
  initial begin : monitor
    rsp_t e;
    logic [1:0] waiting;
    logic [1:0] busy;
    waiting = 2'b00;
    busy    = 2'b00;
    forever begin
      @(negedge clk2);
      if (rst) begin
        waiting = 2'b00;
        busy    = 2'b00;
      end else begin
        if (m0_rvalid || m1_rvalid) begin
          chk("rvalid_exclusive", 32'(m0_rvalid & m1_rvalid), 32'd0);
          chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            chk("rsp_port", 32'(m1_rvalid), 32'(e.port));
            chk("rsp_rdata", m1_rvalid ? m1_rdata : m0_rdata, e.rdata);
            chk("rsp_err", 32'(m1_rvalid ? m1_err : m0_err), 32'(e.err));
          end
        end
        chk("idle_rdata_zero", (m0_rvalid ? 32'd0 : m0_rdata) | (m1_rvalid ? 32'd0 : m1_rdata),
            32'd0);
        chk("idle_err_zero", 32'((!m0_rvalid && m0_err) || (!m1_rvalid && m1_err)), 32'd0);
        // A request that was waiting for a grant must still be there.
        chk("req_held_until_gnt", 32'({waiting[1] & !m1_req, waiting[0] & !m0_req}), 32'd0);
        if (m0_gnt)                          begin busy[0] = 1'b1; waiting[0] = 1'b0; end
        else if (m0_rvalid)                  begin busy[0] = 1'b0; waiting[0] = 1'b0; end
        else if (!busy[0] && m0_req)         waiting[0] = 1'b1;
        if (m1_gnt)                          begin busy[1] = 1'b1; waiting[1] = 1'b0; end
        else if (m1_rvalid)                  begin busy[1] = 1'b0; waiting[1] = 1'b0; end
        else if (!busy[1] && m1_req)         waiting[1] = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  // One complete access on one port. Returns the grant and rvalid cycle numbers.
  task automatic access(input logic port, input logic we, input logic [1:0] size,
                        input logic [9:0] addr, input logic [31:0] wdata, input int delay,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        output int gc, output int rc);
    logic seen;
    logic stall_ok;
    int   lat;
    if (!exp_err)
      cmd_q.push_back('{we: we, size: size, addr: addr, wdata: wdata, delay: 16'(delay)});
    rsp_q.push_back('{port: port, rdata: exp_rdata, err: exp_err});
    if (port) begin
      m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end
    seen = 1'b0;
    gc   = -1;
    rc   = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk2);
      if (port ? m1_gnt : m0_gnt) begin
        seen = 1'b1;
        gc   = cyc;
      end
    end
    chk("gnt_seen", 32'(seen), 32'd1);
    if (seen) begin
      if (!port) chk("stall_at_gnt", 32'(ma_stall), 32'd1);
      seen     = 1'b0;
      stall_ok = 1'b1;
      lat      = 0;
      for (int n = 1; n < 60 && !seen; n++) begin
        @(negedge clk2);
        if (n == 1) chk("mem_en_after_gnt", 32'(mem_en), 32'(!exp_err));
        if (port ? m1_rvalid : m0_rvalid) begin
          seen = 1'b1;
          lat  = n;
          rc   = cyc;
        end else if (!port && !ma_stall) begin
          stall_ok = 1'b0;
        end
      end
      chk("rvalid_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), exp_err ? 32'd1 : 32'(delay + 2));
      if (!port) begin
        chk("stall_held", 32'(stall_ok), 32'd1);
        chk("stall_low_at_rvalid", 32'(ma_stall), 32'd0);
      end
    end
    @(posedge clk2);
    #1;
    if (port) m1_req = 1'b0;
    else      m0_req = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  initial begin : main
    int g0, r0, g1, r1;
    int   gcyc[$];
    logic gport[$];
    int   rv0, rv1;

    m0_req = 1'b0; m0_we = 1'b0; m0_size = SzB; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_size = SzB; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'd0;
    mem_model[10'h010] = 32'hDEADBEEF;
    mem_model[10'h040] = 32'h11111111;
    mem_model[10'h044] = 32'h22222222;
    mem_model[10'h013] = 32'h000000A5;
    mem_model[10'h012] = 32'h0000BEEF;
    mem_model[10'h030] = 32'hCAFEF00D;
    mem_model[10'h034] = 32'h0BADC0DE;

    // Reset state, with m0_req high: no grant, but ma_stall follows its equation.
    tick(2);
    m0_req = 1'b1;
    @(negedge clk2);
    chk("reset_ctrl_outputs",
        32'({m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_en, mem_we}), 32'd0);
    chk("reset_data_outputs", m0_rdata | m1_rdata | mem_wdata, 32'd0);
    chk("reset_ma_stall", 32'(ma_stall), 32'd1);
    m0_req = 1'b0;
    @(posedge clk2);
    #1 rst = 1'b0;
    tick(1);

    // Test 1: reset in the middle of a BUSY that never completes.
    cmd_q.push_back('{we: 1'b0, size: SzW, addr: 10'h008, wdata: 32'd0, delay: 16'd999});
    m0_we = 1'b0; m0_size = SzW; m0_addr = 10'h008; m0_wdata = 32'd0; m0_req = 1'b1;
    @(negedge clk2);
    chk("t1_gnt", 32'(m0_gnt), 32'd1);
    @(negedge clk2);
    chk("t1_mem_en_busy", 32'(mem_en), 32'd1);
    @(posedge clk2);
    #2 rst = 1'b1;
    #1;
    chk("t1_mem_en_drops", 32'(mem_en), 32'd0);
    chk("t1_outputs_zero", 32'({m0_gnt, m0_rvalid, m1_gnt, m1_rvalid}), 32'd0);
    m0_req = 1'b0;
    @(posedge clk2);
    #1 rst = 1'b0;
    tick(1);

    // Test 3: both ports requesting continuously; port 0 first after reset, then strict
    // alternation every 3 cycles.
    for (int k = 0; k < 2; k++) begin
      cmd_q.push_back('{we: 1'b0, size: SzW, addr: 10'h040, wdata: 32'd0, delay: 16'd0});
      cmd_q.push_back('{we: 1'b0, size: SzW, addr: 10'h044, wdata: 32'd0, delay: 16'd0});
      rsp_q.push_back('{port: 1'b0, rdata: 32'h11111111, err: 1'b0});
      rsp_q.push_back('{port: 1'b1, rdata: 32'h22222222, err: 1'b0});
    end
    m0_we = 1'b0; m0_size = SzW; m0_addr = 10'h040; m0_wdata = 32'd0;
    m1_we = 1'b0; m1_size = SzW; m1_addr = 10'h044; m1_wdata = 32'd0;
    m0_req = 1'b1; m1_req = 1'b1;
    rv0 = 0;
    rv1 = 0;
    for (int n = 0; n < 30 && (rv0 < 2 || rv1 < 2); n++) begin
      @(negedge clk2);
      if (m0_gnt) begin gcyc.push_back(cyc); gport.push_back(1'b0); end
      if (m1_gnt) begin gcyc.push_back(cyc); gport.push_back(1'b1); end
      if (m0_rvalid) rv0++;
      if (m1_rvalid) rv1++;
      @(posedge clk2);
      #1;
      if (rv0 >= 2) m0_req = 1'b0;
      if (rv1 >= 2) m1_req = 1'b0;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("t3_grant_count", 32'(gcyc.size()), 32'd4);
    for (int i = 0; i < gcyc.size() && i < 4; i++) begin
      chk("t3_grant_port", 32'(gport[i]), 32'(i % 2));
      if (i > 0) chk("t3_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    tick(2);

    // Test 2: best-case load.
    access(1'b0, 1'b0, SzW, 10'h010, 32'd0, 0, 32'hDEADBEEF, 1'b0, g0, r0);
    // Test 4: misaligned halfword on port 1.
    access(1'b1, 1'b0, SzH, 10'h003, 32'd0, 0, 32'd0, 1'b1, g1, r1);
    // Test 5: store with a slow memory, then read it back from the other port.
    access(1'b0, 1'b1, SzW, 10'h020, 32'h12345678, 4, 32'd0, 1'b0, g0, r0);
    access(1'b1, 1'b0, SzW, 10'h020, 32'd0, 0, 32'h12345678, 1'b0, g1, r1);
    // Size/alignment boundaries.
    access(1'b0, 1'b0, SzW, 10'h022, 32'd0, 0, 32'd0, 1'b1, g0, r0);
    access(1'b1, 1'b0, 2'd3, 10'h000, 32'd0, 0, 32'd0, 1'b1, g1, r1);
    access(1'b0, 1'b0, SzB, 10'h013, 32'd0, 1, 32'h000000A5, 1'b0, g0, r0);
    access(1'b1, 1'b0, SzH, 10'h012, 32'd0, 0, 32'h0000BEEF, 1'b0, g1, r1);
    tick(1);

    // Test 6: m0 requests while m1 is in BUSY and must wait for the next IDLE.
    fork
      access(1'b1, 1'b0, SzW, 10'h030, 32'd0, 3, 32'hCAFEF00D, 1'b0, g1, r1);
      begin
        tick(2);
        access(1'b0, 1'b0, SzW, 10'h034, 32'd0, 0, 32'h0BADC0DE, 1'b0, g0, r0);
      end
    join
    chk("t6_m0_waits_for_idle", 32'(g0), 32'(r1 + 1));
    tick(3);

    chk("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
